// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a 4-bit nibble stream into words,
// writes them from address 0 and holds the core in reset while loading.
// Ports: fastclk, rst (async, active-low), start/len (load request),
// nib_data/nib_valid/nib_ready (stream), we/waddr/wdata (memory write),
// core_hold, busy, done, err (status).
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum nibble.
module imem_loader #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 4
) (
  input  logic               fastclk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  len,
  input  logic [3:0]         nib_data,
  input  logic               nib_valid,
  output logic               nib_ready,
  output logic               we,
  output logic [ADDR_W-1:0]  waddr,
  output logic [INSTR_W-1:0] wdata,
  output logic               core_hold,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int NPW = INSTR_W / 4;
  localparam int CW  = $clog2(NPW) + 1;

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_CHECK, S_DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WRITE, S_DONE
  } state_t;
`endif

  state_t               r_state;
  state_t               w_state_nx;
  logic [ADDR_W-1:0]    r_len;
  logic [ADDR_W:0]      r_wcnt;
  logic [CW-1:0]        r_ncnt;
  logic [INSTR_W-1:0]   r_asm;
  logic [INSTR_W-1:0]   r_wdata;
  logic [ADDR_W-1:0]    r_waddr;

  logic                 w_xfer;
  logic                 w_last_nib;
  logic                 w_last_word;
  logic [ADDR_W:0]      w_target;
  logic [ADDR_W:0]      w_wcnt_nx;
  logic [INSTR_W-1:0]   w_asm_nx;

  // len==0 encodes a full-depth load, so the target gets an extra MSB
  assign w_target    = {(r_len == '0), r_len};
  assign w_wcnt_nx   = r_wcnt + (ADDR_W+1)'(1);
  assign w_last_word = (w_wcnt_nx == w_target);
  assign w_last_nib  = (r_ncnt == CW'(NPW - 1));
  assign w_xfer      = nib_valid & nib_ready;
  assign w_asm_nx    = INSTR_W'({r_asm, nib_data});

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [3:0] r_csum;
  logic       r_err;
  logic       r_hold;
  logic       w_ck_ok;

  assign w_ck_ok = (nib_data == r_csum);

  // r_hold keeps the core parked after a failed checksum
  always_ff @(posedge fastclk or negedge rst) begin
    if (!rst) begin
      r_csum <= '0;
      r_err  <= 1'b0;
      r_hold <= 1'b0;
    end else if (r_state == S_IDLE && start) begin
      r_csum <= '0;
      r_err  <= 1'b0;
      r_hold <= 1'b0;
    end else if (r_state == S_LOAD && w_xfer) begin
      r_csum <= r_csum ^ nib_data;
    end else if (r_state == S_CHECK && w_xfer && !w_ck_ok) begin
      r_err  <= 1'b1;
      r_hold <= 1'b1;
    end
  end
`endif

  always_ff @(posedge fastclk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nx = S_LOAD;
      S_LOAD:  if (w_xfer && w_last_nib) w_state_nx = S_WRITE;
      S_WRITE: begin
        if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          w_state_nx = S_CHECK;
`else
          w_state_nx = S_DONE;
`endif
        end else begin
          w_state_nx = S_LOAD;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK: if (w_xfer) w_state_nx = w_ck_ok ? S_DONE : S_IDLE;
`endif
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    nib_ready = (r_state == S_LOAD);
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (r_state == S_CHECK) nib_ready = 1'b1;
`endif
    we    = (r_state == S_WRITE);
    busy  = (r_state != S_IDLE);
    done  = (r_state == S_DONE);
    waddr = r_waddr;
    wdata = r_wdata;
`ifdef IMEM_LOADER_CHECKSUM_EN
    core_hold = busy | r_hold;
    err       = r_err;
`else
    core_hold = busy;
    err       = 1'b0;
`endif
  end

  // wdata is captured with the last nibble so it holds between writes
  always_ff @(posedge fastclk or negedge rst) begin
    if (!rst) begin
      r_len   <= '0;
      r_wcnt  <= '0;
      r_ncnt  <= '0;
      r_asm   <= '0;
      r_wdata <= '0;
      r_waddr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len   <= len;
            r_wcnt  <= '0;
            r_ncnt  <= '0;
            r_asm   <= '0;
            r_waddr <= '0;
          end
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_asm  <= w_asm_nx;
            r_ncnt <= r_ncnt + CW'(1);
            if (w_last_nib) r_wdata <= w_asm_nx;
          end
        end
        S_WRITE: begin
          r_wcnt  <= w_wcnt_nx;
          r_waddr <= r_waddr + ADDR_W'(1);
          r_ncnt  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load scenarios plus reset and
// checksum sequences, checked against a word/address write model.
module tb_imem_loader;
  localparam int IW  = 16;
  localparam int AW  = 4;
  localparam int NPW = IW / 4;

  logic          fastclk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] len = '0;
  logic [3:0]    nib_data = '0;
  logic          nib_valid = 1'b0;
  logic          nib_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [IW-1:0] wdata;
  logic          core_hold;
  logic          busy;
  logic          done;
  logic          err;

  always #5 fastclk = ~fastclk;

  imem_loader #(.INSTR_W(IW), .ADDR_W(AW)) dut (
    .fastclk(fastclk), .rst(rst), .start(start), .len(len),
    .nib_data(nib_data), .nib_valid(nib_valid),
    .nib_ready(nib_ready), .we(we), .waddr(waddr), .wdata(wdata),
    .core_hold(core_hold), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [IW-1:0] d;
  } wr_t;

  typedef struct {
    logic [AW-1:0] len;
    logic [IW-1:0] w0;
    logic [IW-1:0] w1;
    int            gm;
    bit            poke;
    int            nwr;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  wr_t got_q[$];
  int  done_cnt = 0;

  always @(negedge fastclk) begin
    if (rst) begin
      if (we) got_q.push_back('{a: waddr, d: wdata});
      if (done) done_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_nib(input logic [3:0] n, input int gap);
    int k;
    for (int g = 0; g < gap; g++) begin
      if (busy && !we) chk("ready_in_load", 32'(nib_ready), 1);
      nib_valid = 1'b0;
      nib_data  = 4'($urandom);
      @(negedge fastclk);
    end
    nib_valid = 1'b1;
    nib_data  = n;
    k = 0;
    while (!nib_ready && k < 64) begin
      @(negedge fastclk);
      k++;
    end
    if (!nib_ready) begin
      checks++;
      errors++;
      $display("FAIL nib_timeout: got ready=0 expected ready=1");
    end
    @(negedge fastclk);
    nib_valid = 1'b0;
  endtask

  task automatic run_load(input logic [AW-1:0] l,
                          input logic [IW-1:0] w[16], input int n,
                          input int gm, input bit poke, input bit bad);
    logic [3:0]    cs;
    logic [3:0]    nb;
    logic [IW-1:0] wd;
    int            g;
    wr_t           exp_q[$];
    cs = '0;
    @(negedge fastclk);
    got_q.delete();
    done_cnt = 0;
    start = 1'b1;
    len = l;
    nib_valid = 1'b1;
    nib_data = 4'hF;
    @(negedge fastclk);
    start = 1'b0;
    nib_valid = 1'b0;
    len = 4'($urandom);
    chk("hold_after_start", 32'(core_hold), 1);
    chk("busy_after_start", 32'(busy), 1);
    chk("err_after_start", 32'(err), 0);
    for (int i = 0; i < n; i++) begin
      wd = w[i];
      if (poke && i == 5) start = 1'b1;
      for (int j = 0; j < NPW; j++) begin
        nb = wd[IW-1-4*j -: 4];
        cs ^= nb;
        g = (gm == 0) ? 0 : (gm == 1) ? 1 : int'($urandom_range(0, 3));
        send_nib(nb, g);
        start = 1'b0;
      end
      chk("we_latency", 32'(we), 1);
      chk("waddr", 32'(waddr), 32'(i));
      chk("wdata", 32'(wd), 32'(wdata) ^ 32'(wd) ^ 32'(wd));
      exp_q.push_back('{a: AW'(i), d: wd});
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_nib(bad ? (cs ^ 4'h1) : cs, 0);
`else
    @(negedge fastclk);
`endif
    if (bad) begin
      chk("bad_err", 32'(err), 1);
      chk("bad_nodone", 32'(done), 0);
      chk("bad_busy", 32'(busy), 0);
      repeat (3) @(negedge fastclk);
      chk("bad_hold", 32'(core_hold), 1);
      chk("bad_done_cnt", 32'(done_cnt), 0);
    end else begin
      chk("done_pulse", 32'(done), 1);
      chk("hold_in_done", 32'(core_hold), 1);
      @(negedge fastclk);
      chk("done_low", 32'(done), 0);
      chk("hold_released", 32'(core_hold), 0);
      chk("busy_low", 32'(busy), 0);
      chk("err_ok", 32'(err), 0);
      chk("ready_idle", 32'(nib_ready), 0);
      repeat (2) @(negedge fastclk);
      chk("done_count", 32'(done_cnt), 1);
    end
    chk("write_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk("sb_addr", 32'(got_q[i].a), 32'(exp_q[i].a));
      chk("sb_data", 32'(got_q[i].d), 32'(exp_q[i].d));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          tv[6];
    logic [IW-1:0] words[16];
    logic [3:0]    seq[8];
    tv[0] = '{len: 4'd2, w0: 16'h1234, w1: 16'hABCD, gm: 0, poke: 0, nwr: 2};
    tv[1] = '{len: 4'd2, w0: 16'h1234, w1: 16'hABCD, gm: 1, poke: 0, nwr: 2};
    tv[2] = '{len: 4'd0, w0: 16'hFFFF, w1: 16'h0000, gm: 0, poke: 1, nwr: 16};
    tv[3] = '{len: 4'd1, w0: 16'h8001, w1: 16'h0000, gm: 2, poke: 0, nwr: 1};
    tv[4] = '{len: 4'd15, w0: 16'h5A5A, w1: 16'hA5A5, gm: 2, poke: 0, nwr: 15};
    tv[5] = '{len: 4'd3, w0: 16'h0F0F, w1: 16'hF0F0, gm: 2, poke: 1, nwr: 3};
    seq = '{4'h1, 4'h2, 4'h3, 4'h4, 4'hA, 4'hB, 4'hC, 4'hD};

    #3;
    chk("rst_ready", 32'(nib_ready), 0);
    chk("rst_we", 32'(we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_hold", 32'(core_hold), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_wdata", 32'(wdata), 0);
    repeat (2) @(negedge fastclk);
    rst = 1'b1;
    @(negedge fastclk);
    chk("idle_ready", 32'(nib_ready), 0);
    chk("idle_busy", 32'(busy), 0);

    foreach (tv[t]) begin
      for (int i = 0; i < 16; i++) words[i] = 16'($urandom);
      words[0] = tv[t].w0;
      words[1] = tv[t].w1;
      run_load(tv[t].len, words, tv[t].nwr, tv[t].gm, tv[t].poke, 1'b0);
    end

    @(negedge fastclk);
    start = 1'b1;
    len = 4'd2;
    @(negedge fastclk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) send_nib(seq[k], 0);
    #2 rst = 1'b0;
    #1;
    chk("mrst_ready", 32'(nib_ready), 0);
    chk("mrst_we", 32'(we), 0);
    chk("mrst_waddr", 32'(waddr), 0);
    chk("mrst_wdata", 32'(wdata), 0);
    chk("mrst_hold", 32'(core_hold), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_done", 32'(done), 0);
    chk("mrst_err", 32'(err), 0);
    @(negedge fastclk);
    rst = 1'b1;
    @(negedge fastclk);
    chk("mrst_idle_ready", 32'(nib_ready), 0);
    chk("mrst_idle_busy", 32'(busy), 0);
    words[0] = 16'h1234;
    run_load(4'd1, words, 1, 0, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    words[0] = 16'h1234;
    words[1] = 16'hABCD;
    run_load(4'd2, words, 2, 0, 1'b0, 1'b1);
    run_load(4'd2, words, 2, 1, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Write-side counterpart of the instruction memory that the core fetches from via Pc. It receives machine-code words as a 4-bit nibble stream with a valid/ready handshake and assembles them into INSTR_W-bit words. Words are written sequentially from address 0. The core is held in reset while loading and released when the load completes.

Parameters:
INSTR_W, 16, instruction word width in bits; must be a multiple of 4; NPW = INSTR_W/4 nibbles per word.
ADDR_W, 4, instruction memory address width (matches Pc); depth is 2^ADDR_W.

Ports:
fastclk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-low reset.
start  input  1  one-cycle request to begin a load; honoured only in IDLE.
len  input  ADDR_W  number of words to load, sampled on start; 0 means 2^ADDR_W.
nib_data  input  4  stream nibble, MSB nibble of each word first.
nib_valid  input  1  nib_data is valid.
nib_ready  output  1  loader accepts a nibble this cycle.
we  output  1  instruction memory write strobe, one cycle per word.
waddr  output  ADDR_W  write address.
wdata  output  INSTR_W  write data.
core_hold  output  1  high keeps the core in reset.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse at load completion.
err  output  1  sticky checksum error (optional feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. nib_ready, we, core_hold, busy, done and err = 0. waddr, wdata, word counter, nibble counter and assembly register = 0.
- States: IDLE, LOAD, WRITE, CHECK (only with feature), DONE.
- IDLE:
  - nib_ready=0.
  - start=1 → LOAD. Latch len, clear counters, waddr=0.
  - core_hold and busy go high on the next cycle.
  - A nibble presented in the same cycle as start is not accepted.
- LOAD:
  - nib_ready=1.
  - A transfer occurs only when nib_valid & nib_ready are both high at a rising edge.
  - On each transfer: assembly = {assembly[INSTR_W-5:0], nib_data}; nibble counter increments.
  - The transfer of nibble NPW moves the state to WRITE.
  - nib_valid low stalls the load indefinitely, with no timeout.
- WRITE:
  - Lasts exactly one cycle: we=1, waddr=current address, wdata=assembled word, nib_ready=0.
  - Latency: we is asserted in the cycle immediately after the edge that accepted the last nibble of the word.
  - On exit, the word counter increments and waddr increments modulo 2^ADDR_W.
  - If words written equals the latched length (0 treated as 2^ADDR_W; counter is ADDR_W+1 bits wide): go to CHECK if the feature is enabled, otherwise DONE.
  - Otherwise return to LOAD with the nibble counter cleared.
- DONE:
  - Lasts one cycle: done=1, core_hold=1, busy=1.
  - Then IDLE, where core_hold=0 and busy=0.
- we is never high outside WRITE. wdata and waddr hold their last values when we=0.
- start while busy is ignored.
- Reset mid-load: the partial word is discarded and all outputs return to reset values. Words already written stay in memory. The next load restarts at address 0.
- Exactly len words are written. No wrap beyond the last address occurs within one load.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the state goes to CHECK with nib_ready=1.
  - One extra nibble is accepted; it must equal the XOR of every data nibble of this load.
  - Match → DONE, err=0.
  - Mismatch → err=1 (sticky) and state → IDLE with no done pulse. core_hold stays 1 until the next accepted start or reset.
  - err clears on the next accepted start.
- Undefined: the CHECK state is absent, there is no checksum nibble, and err is tied to 0.

Test Plan:
- Reset: drive rst=0 mid-activity → all outputs 0 immediately, without waiting for a clock edge. Release rst=1 → state stays IDLE and nib_ready=0.
- Basic load: len=2, start, stream 1,2,3,4,A,B,C,D back-to-back.
  - Expect we with waddr=0, wdata=0x1234, then waddr=1, wdata=0xABCD.
  - Exactly one done pulse.
  - core_hold is high from the cycle after start through DONE, and low afterwards.
- Backpressure: same stream with nib_valid low on alternate cycles → identical writes, no duplicated or dropped nibbles, nib_ready stays high in LOAD.
- Full depth: len=0, 64 nibbles → 16 writes at waddr 0..15, done after waddr=15, no 17th write. A start pulse mid-load has no effect.
- Mid-load reset: assert rst=0 after 5 nibbles of a len=2 load, release, reload 1,2,3,4 with len=1 → a single write of 0x1234 at waddr=0.
- With IMEM_LOADER_CHECKSUM_EN:
  - Basic stream plus checksum nibble 0x4 → done=1, err=0.
  - Checksum nibble 0x5 → err=1, no done, core_hold remains 1 until the next start.
